// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// State encodings, the queue entry layout and the PC increment live here.
package if_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // One queue entry: the fetched word and the address of the word after it.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous DEPTH x 64-bit FIFO with push, pop, a dominant flush and a
// registered head; a pushed word reaches the head one cycle after its push edge.
module if_inst_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output fetch_entry_t             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_after_pop;
    logic           push_eff;
    logic           pop_eff;

    always_comb begin
        push_eff        = push && (count < CW'(DEPTH));
        pop_eff         = pop && head_valid;
        rd_ptr_next     = pop_eff ? (rd_ptr + AW'(1)) : rd_ptr;
        count_after_pop = count - CW'(pop_eff);
    end

    always_ff @(posedge CLK) begin
        if (push_eff && !CLR && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head only sees words already in storage before this edge: no bypass.
    always_ff @(posedge CLK) begin
        if (CLR || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next;
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            head_valid <= (count_after_pop != '0);
            head_data  <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues word fetches over a req/ack handshake,
// queues returned words with their PC+4, and flushes/refetches on redirect.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_addr,
    input  logic                     id_ready,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc4,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [1:0]               dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: imem_req/imem_addr stay stable from issue until the cycle
    // imem_ack=1 and are never withdrawn; a head entry transfers on an edge
    // where out_valid && id_ready, unless a redirect flushes it that cycle.

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    imem_addr_q;
    logic [31:0]    ack_pc4;
    logic           push;
    logic           pop;
    logic           issue;
    logic           can_issue;
    logic [CW-1:0]  occupancy_after_pop;
    fetch_entry_t   push_data;
    fetch_entry_t   head_data;
    logic           head_valid;

    always_comb begin
        ack_pc4             = imem_addr_q + PC_STEP;
        pop                 = head_valid && id_ready && !redirect_valid;
        push                = (state == S_WAIT) && imem_ack && !redirect_valid;
        occupancy_after_pop = q_count - CW'(pop);
        can_issue           = occupancy_after_pop < CW'(DEPTH);
        push_data.inst      = imem_rdata;
        push_data.pc4       = ack_pc4;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect during an outstanding request parks in S_DROP until its ack.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && can_issue) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_next = S_IDLE;
                end else if (redirect_valid) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state != S_IDLE);
        issue     = (state == S_IDLE) && (state_next == S_WAIT);
        imem_addr = imem_addr_q;
        dbg_state = state;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            fetch_pc    <= RESET_PC;
            imem_addr_q <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
            end else if (push) begin
                fetch_pc <= ack_pc4;
            end
            if (issue) begin
                imem_addr_q <= fetch_pc;
            end
        end
    end

    if_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .CLR        (CLR),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (q_count)
    );

    always_comb begin
        out_valid = head_valid;
        out_inst  = head_valid ? head_data.inst : NOP_INST;
        out_pc4   = head_valid ? head_data.pc4  : NOP_INST;
    end

endmodule
